// File: rtl/terminal_inject_arbiter_pkg.sv
// Shared types and sizing helpers for the terminal inject arbiter.
// Widths are functions because N_REQ and BURST are per-instance parameters.
package inject_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_W = 16;

    function automatic int id_w(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

    function automatic int bcnt_w(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/terminal_inject_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible index after i_last, wrapping.
// With i_excl set, i_last itself is never returned.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_elig,
    input  logic [ID_W-1:0]  i_last,
    input  logic             i_excl,
    output logic             o_found,
    output logic [ID_W-1:0]  o_idx
);

    always_comb begin
        int          v_cand;
        logic [ID_W-1:0] v_idx;
        o_found = 1'b0;
        o_idx   = '0;
        v_cand  = 0;
        v_idx   = '0;
        // offset N_REQ lands back on i_last, which is the lowest priority
        for (int off = 1; off <= N_REQ; off++) begin
            v_cand = int'(i_last) + off;
            if (v_cand >= N_REQ) begin
                v_cand = v_cand - N_REQ;
            end
            v_idx = ID_W'(v_cand);
            if (!o_found && i_elig[v_idx] && !(i_excl && off == N_REQ)) begin
                o_found = 1'b1;
                o_idx   = v_idx;
            end
        end
    end

endmodule

// File: rtl/terminal_inject_arbiter.sv
// Round-robin arbiter with per-grant burst quota feeding one router terminal port.
// A one-entry hold register is refilled in the same cycle the router pops it.
module terminal_inject_arbiter
    import inject_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PAKG_SIZE = 32,
    parameter int BURST     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_pndng_i,
    input  logic [N_REQ*PAKG_SIZE-1:0] req_data_i,
    input  logic [N_REQ-1:0]           req_mask_i,
    output logic [N_REQ-1:0]           req_pop_o,
    output logic                       pndng_o,
    output logic [PAKG_SIZE-1:0]       data_o,
    input  logic                       popin_i,
    output logic [id_w(N_REQ)-1:0]     gnt_id_o,
    output logic [PKT_CNT_W-1:0]       pkt_cnt_o
);

    localparam int ID_W   = id_w(N_REQ);
    localparam int BCNT_W = bcnt_w(BURST);
    localparam logic [BCNT_W-1:0] BURST_V  = BCNT_W'(BURST);
    localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
    localparam logic [ID_W-1:0]   LAST_RST = ID_W'(N_REQ - 1);

    arb_state_e           r_state;
    logic [PAKG_SIZE-1:0] r_hold;
    logic [ID_W-1:0]      r_gnt;
    logic [ID_W-1:0]      r_last;
    logic [BCNT_W-1:0]    r_burst;
    logic [PKT_CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0]     w_elig;
    logic                 w_offer;
    logic                 w_found;
    logic [ID_W-1:0]      w_rr_idx;
    logic                 w_last_elig;
    logic                 w_pop_en;
    logic [ID_W-1:0]      w_sel;
    logic [BCNT_W-1:0]    w_next_burst;
    logic [PAKG_SIZE-1:0] w_sel_data;
    logic                 w_consume;

    assign w_elig      = req_pndng_i & req_mask_i;
    assign w_offer     = (r_state == OFFER);
    assign w_last_elig = w_elig[r_last];
    assign w_consume   = w_offer & popin_i;

    // While offering, the search skips the current owner so a competitor wins once the quota is spent
    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_last  (r_last),
        .i_excl  (w_offer),
        .o_found (w_found),
        .o_idx   (w_rr_idx)
    );

    always_comb begin
        w_pop_en     = 1'b0;
        w_sel        = w_rr_idx;
        w_next_burst = BCNT_ONE;
        if (!w_offer) begin
            w_pop_en = w_found;
        end else if (popin_i) begin
            if (r_burst < BURST_V && w_last_elig) begin
                w_pop_en     = 1'b1;
                w_sel        = r_last;
                w_next_burst = r_burst + BCNT_ONE;
            end else if (w_found) begin
                w_pop_en = 1'b1;
            end else if (w_last_elig) begin
                // sole eligible requester: quota restarts, nobody is starved
                w_pop_en = 1'b1;
                w_sel    = r_last;
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel == ID_W'(k)) begin
                w_sel_data = req_data_i[k*PAKG_SIZE +: PAKG_SIZE];
            end
        end
    end

    always_comb begin
        req_pop_o = '0;
        if (w_pop_en && rst_i) begin
            req_pop_o[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_last  <= LAST_RST;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_consume) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_pop_en) begin
                r_state <= OFFER;
                r_hold  <= w_sel_data;
                r_gnt   <= w_sel;
                r_last  <= w_sel;
                r_burst <= w_next_burst;
            end else if (w_consume) begin
                r_state <= IDLE;
            end
        end
    end

    assign pndng_o   = w_offer;
    assign data_o    = r_hold;
    assign gnt_id_o  = r_gnt;
    assign pkt_cnt_o = r_cnt;

endmodule

// File: tb/tb_terminal_inject_arbiter.sv
// Bench for terminal_inject_arbiter: directed vector table, backpressure and
// counter-wrap sequences, and random traffic against a rule-level reference model.
module tb_terminal_inject_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int B = 2;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_pndng_i;
    logic [N*W-1:0]   req_data_i;
    logic [N-1:0]     req_mask_i;
    logic [N-1:0]     req_pop_o;
    logic             pndng_o;
    logic [W-1:0]     data_o;
    logic             popin_i;
    logic [1:0]       gnt_id_o;
    logic [15:0]      pkt_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    terminal_inject_arbiter #(
        .N_REQ     (N),
        .PAKG_SIZE (W),
        .BURST     (B)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_pndng_i (req_pndng_i),
        .req_data_i  (req_data_i),
        .req_mask_i  (req_mask_i),
        .req_pop_o   (req_pop_o),
        .pndng_o     (pndng_o),
        .data_o      (data_o),
        .popin_i     (popin_i),
        .gnt_id_o    (gnt_id_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst_n;
        logic [3:0]  pnd;
        logic [3:0]  msk;
        bit          popin;
        logic [3:0]  e_pop;
        bit          e_pnd;
        logic [31:0] e_data;
        int          e_gnt;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [3:0] p, logic [3:0] m, bit pi,
                                logic [3:0] ep, bit epn, logic [31:0] ed, int eg, int ec);
        vec_t v;
        v.rst_n = r; v.pnd = p; v.msk = m; v.popin = pi;
        v.e_pop = ep; v.e_pnd = epn; v.e_data = ed; v.e_gnt = eg; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int k = 0; k < N; k++) begin
            req_data_i[k*W +: W] = base | 32'(k);
        end
    endtask

    task automatic drive(input bit r, input logic [3:0] p, input logic [3:0] m, input bit pi);
        @(negedge clk);
        rst_i       = r;
        req_pndng_i = p;
        req_mask_i  = m;
        popin_i     = pi;
        #1;
    endtask

    // Reference: pick by the round-robin rule on plain integers
    function automatic int pick(input logic [3:0] e, input int last, input bit excl);
        int lim;
        logic [1:0] ix;
        lim = excl ? N - 1 : N;
        for (int off = 1; off <= lim; off++) begin
            ix = 2'((last + off) % N);
            if (e[ix]) return int'(ix);
        end
        return -1;
    endfunction

    // model state
    bit          m_full;
    logic [31:0] m_hold;
    int          m_gnt, m_last, m_burst;
    logic [15:0] m_cnt;
    logic [31:0] q[N][$];

    initial begin
        int seq;
        int w, nb;
        logic [3:0] e, p, m;
        bit pi;
        logic [3:0] ep;

        rst_i = 1'b0; req_pndng_i = '1; req_mask_i = '1; popin_i = 1'b0;
        set_data(32'hCAFE0000);

        // reset held for three cycles with everybody pending
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'b1111, 4'b1111, 1'b0);
            chk("rst_pop", 32'(req_pop_o), 32'd0);
            @(posedge clk); #1;
            chk("rst_pndng", 32'(pndng_o), 32'd0);
            chk("rst_cnt", 32'(pkt_cnt_o), 32'd0);
            chk("rst_data", data_o, 32'd0);
            chk("rst_gnt", 32'(gnt_id_o), 32'd0);
        end

        // all pending, router pops every cycle: 0,0,1,1,2,2,3,3,0
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b0001, 1, 32'hCAFE0000, 0, 0));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b0001, 1, 32'hCAFE0000, 0, 1));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b0010, 1, 32'hCAFE0001, 1, 2));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b0010, 1, 32'hCAFE0001, 1, 3));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b0100, 1, 32'hCAFE0002, 2, 4));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b0100, 1, 32'hCAFE0002, 2, 5));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b1000, 1, 32'hCAFE0003, 3, 6));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b1000, 1, 32'hCAFE0003, 3, 7));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'b0001, 1, 32'hCAFE0000, 0, 8));
        // reset, then a single request from requester 2
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'b0000, 0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 4'b0100, 4'hF, 0, 4'b0100, 1, 32'hCAFE0002, 2, 0));
        tbl.push_back(mk(1, 4'b0000, 4'hF, 1, 4'b0000, 0, 32'h0, 2, 1));
        // requester 1 masked; requester 0 alone keeps getting served
        tbl.push_back(mk(1, 4'b0011, 4'b1101, 1, 4'b0001, 1, 32'hCAFE0000, 0, 1));
        tbl.push_back(mk(1, 4'b0011, 4'b1101, 1, 4'b0001, 1, 32'hCAFE0000, 0, 2));
        tbl.push_back(mk(1, 4'b0011, 4'b1101, 1, 4'b0001, 1, 32'hCAFE0000, 0, 3));
        tbl.push_back(mk(1, 4'b0011, 4'b1101, 1, 4'b0001, 1, 32'hCAFE0000, 0, 4));
        tbl.push_back(mk(1, 4'b0011, 4'b1101, 1, 4'b0001, 1, 32'hCAFE0000, 0, 5));
        // reset while offering drops the packet; first grant goes to requester 0
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'b0000, 0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'b0001, 1, 32'hCAFE0000, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].pnd, tbl[i].msk, tbl[i].popin);
            chk($sformatf("tbl%0d_pop", i), 32'(req_pop_o), 32'(tbl[i].e_pop));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_pndng", i), 32'(pndng_o), 32'(tbl[i].e_pnd));
            if (tbl[i].e_pnd) chk($sformatf("tbl%0d_data", i), data_o, tbl[i].e_data);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt_id_o), 32'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d_cnt", i), 32'(pkt_cnt_o), 32'(tbl[i].e_cnt));
        end

        // backpressure: held packet stays put while sources change under it
        set_data(32'hDEAD0000);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 4'b1111, 4'b1111, 1'b0);
            chk("bp_pop", 32'(req_pop_o), 32'd0);
            @(posedge clk); #1;
            chk("bp_pndng", 32'(pndng_o), 32'd1);
            chk("bp_data", data_o, 32'hCAFE0000);
        end
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        chk("bp_release_pop", 32'(req_pop_o), 32'b0001);
        chk("bp_release_ones", 32'($countones(req_pop_o)), 32'd1);
        @(posedge clk); #1;
        chk("bp_release_data", data_o, 32'hDEAD0000);
        chk("bp_release_cnt", 32'(pkt_cnt_o), 32'd1);

        // random traffic against the reference model
        drive(1'b0, 4'b0000, 4'b1111, 1'b0);
        @(posedge clk); #1;
        m_full = 0; m_hold = '0; m_gnt = 0; m_last = N - 1; m_burst = 0; m_cnt = '0;
        seq = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 99) < 22) begin
                    q[k].push_back({8'(k), 24'(seq)});
                    seq++;
                end
            end
            for (int k = 0; k < N; k++) begin
                p[k] = (q[k].size() > 0);
                req_data_i[k*W +: W] = p[k] ? q[k][0] : 32'($urandom);
                m[k] = ($urandom_range(0, 99) < 80);
            end
            pi = ($urandom_range(0, 99) < 60);
            rst_i = 1'b1; req_pndng_i = p; req_mask_i = m; popin_i = pi;
            #1;
            e = p & m;
            w = -1; nb = 1;
            if (!m_full) begin
                w = pick(e, m_last, 0);
            end else if (pi) begin
                if (m_burst < B && e[2'(m_last)]) begin
                    w = m_last; nb = m_burst + 1;
                end else begin
                    w = pick(e, m_last, 1);
                    if (w < 0 && e[2'(m_last)]) w = m_last;
                end
            end
            ep = (w < 0) ? 4'b0000 : (4'b0001 << w);
            chk("rnd_pop", 32'(req_pop_o), 32'(ep));
            @(posedge clk); #1;
            if (m_full && pi) m_cnt = m_cnt + 16'd1;
            if (w >= 0) begin
                m_hold = q[w].pop_front();
                m_gnt = w; m_last = w; m_burst = nb; m_full = 1;
            end else if (m_full && pi) begin
                m_full = 0;
            end
            chk("rnd_pndng", 32'(pndng_o), 32'(m_full));
            if (m_full) chk("rnd_data", data_o, m_hold);
            chk("rnd_gnt", 32'(gnt_id_o), 32'(m_gnt));
            chk("rnd_cnt", 32'(pkt_cnt_o), 32'(m_cnt));
        end

        // packet counter wrap: 65535 deliveries, then one more
        set_data(32'hCAFE0000);
        drive(1'b0, 4'b0001, 4'b1111, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 4'b0001, 4'b1111, 1'b1);
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap_ffff", 32'(pkt_cnt_o), 32'h0000FFFF);
        @(posedge clk); #1;
        chk("wrap_zero", 32'(pkt_cnt_o), 32'd0);
        chk("wrap_pndng", 32'(pndng_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
